// File: rtl/bram_lsu_if.sv
// Request/response and RAM-side signal bundle for bram_lsu.
// The slave modport is the LSU's view; master is the core/RAM side.
interface bram_lsu_if;
  localparam int unsigned ADDR_W = 11;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic              ram_wren;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_raddr, ram_waddr, ram_wdata, ram_wren
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_raddr, ram_waddr, ram_wdata, ram_wren
  );
endinterface

// File: rtl/bram_lsu.sv
// Load/store unit for the 2 KiB unaligned block RAM; sub-word stores use read-modify-write.
// Define BRAM_LSU_ALIGN_CHECK_EN to reject misaligned half/word requests.
module bram_lsu (
  input  logic        i_clk,
  input  logic        i_rst,
  bram_lsu_if.slave   bus
);
  localparam int unsigned ADDR_W = 11;

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StResp} state_e;

  state_e            r_state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [ADDR_W-1:0] r_ram_raddr;
  logic [ADDR_W-1:0] r_ram_waddr;
  logic [31:0]       r_ram_wdata;
  logic              r_ram_wren;

  logic        w_misalign;
  logic        w_reject;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

`ifdef BRAM_LSU_ALIGN_CHECK_EN
  assign w_misalign = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject = (bus.req_size == 2'd3) || w_misalign;

  always_comb begin
    w_ext = bus.ram_rdata;
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & bus.ram_rdata[7]}}, bus.ram_rdata[7:0]};
      2'd1:    w_ext = {{16{r_signed & bus.ram_rdata[15]}}, bus.ram_rdata[15:0]};
      default: w_ext = bus.ram_rdata;
    endcase
  end

  // Only byte and half stores reach the merge path; word stores bypass the read.
  assign w_merge = (r_size == 2'd0) ? {bus.ram_rdata[31:8], r_wdata[7:0]}
                                    : {bus.ram_rdata[31:16], r_wdata[15:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_write     <= 1'b0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_ram_raddr <= '0;
      r_ram_waddr <= '0;
      r_ram_wdata <= '0;
      r_ram_wren  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.req_valid) begin
            r_write     <= bus.req_write;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata[15:0];
            r_req_ready <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            if (w_reject) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= StResp;
            end else if (bus.req_write && (bus.req_size == 2'd2)) begin
              r_ram_wren  <= 1'b1;
              r_ram_waddr <= bus.req_addr;
              r_ram_wdata <= bus.req_wdata;
              r_state     <= StWrite;
            end else begin
              r_ram_raddr <= bus.req_addr;
              r_state     <= StRead;
            end
          end
        end
        StRead: r_state <= StWait;
        StWait: begin
          r_ram_raddr <= '0;
          if (!r_write) begin
            r_rsp_rdata <= w_ext;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_ram_wren  <= 1'b1;
            r_ram_waddr <= r_addr;
            r_ram_wdata <= w_merge;
            r_state     <= StWrite;
          end
        end
        StWrite: begin
          r_ram_wren  <= 1'b0;
          r_ram_waddr <= '0;
          r_ram_wdata <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.ram_raddr = r_ram_raddr;
  assign bus.ram_waddr = r_ram_waddr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_wren  = r_ram_wren;
endmodule

// File: tb/tb_bram_lsu.sv
// Randomized bench for bram_lsu against a byte-array reference model, with an
// unaligned wrapping RAM model driving ram_rdata.
module tb_bram_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_lsu_if bus ();

  bram_lsu dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ram_mem [2048];
  logic [7:0] ref_mem [2048];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Unaligned RAM: registered 4-byte read, 4-byte write, addresses wrap at 2 KiB.
  initial begin
    logic [10:0] a;
    logic [10:0] w;
    for (int i = 0; i < 2048; i++) ram_mem[i] = 8'((i * 7 + 3) & 255);
    forever begin
      @(posedge clk);
      a = bus.ram_raddr;
      bus.ram_rdata <= {ram_mem[a + 11'd3], ram_mem[a + 11'd2], ram_mem[a + 11'd1], ram_mem[a]};
      if (bus.ram_wren) begin
        for (int k = 0; k < 4; k++) begin
          w = bus.ram_waddr + 11'(k);
          ram_mem[w] = bus.ram_wdata[8*k +: 8];
        end
      end
    end
  end

  function automatic logic misaligned(input logic [1:0] sz, input logic [10:0] ad);
`ifdef BRAM_LSU_ALIGN_CHECK_EN
    return (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [10:0] ad);
    int nbytes;
    longint unsigned v;
    v = 0;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) v += longint'(ref_mem[11'(ad + 11'(i))]) << (8 * i);
    if (sg && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1))) v += 64'h1_0000_0000 - (64'd1 << (8 * nbytes));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [10:0] ad, input logic [31:0] wd);
    int nbytes;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) ref_mem[11'(ad + 11'(i))] = wd[8*i +: 8];
  endtask

  // Called just after a negedge with the LSU idle; returns just after a negedge.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [10:0] ad, input logic [31:0] wd, input int stall);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat, exp_wr, lat, wr_cnt;
    exp_err = (sz == 2'd3) || misaligned(sz, ad);
    if (exp_err) begin
      exp_lat = 1; exp_wr = 0; exp_data = 32'd0;
    end else if (!wr) begin
      exp_lat = 3; exp_wr = 0; exp_data = model_load(sz, sg, ad);
    end else begin
      exp_lat = (sz == 2'd2) ? 2 : 4; exp_wr = 1; exp_data = 32'd0;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = ad;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    wr_cnt = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.ram_wren) wr_cnt++;
      if (bus.rsp_valid) lat = k;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", bus.rsp_rdata, exp_data);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (bus.ram_wren) wr_cnt++;
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rdata", bus.rsp_rdata, exp_data);
      check("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("wren_pulses", 32'(wr_cnt), 32'(exp_wr));
    check("post_rsp_idle", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    if (!exp_err && wr) model_store(sz, ad, wd);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'((i * 7 + 3) & 255);
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_ram_ctl", {bus.ram_raddr, bus.ram_waddr, 9'd0, bus.ram_wren}, 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the plan.
    do_req(1'b1, 2'd2, 1'b0, 11'h001, 32'h12345678, 0);
    do_req(1'b0, 2'd2, 1'b0, 11'h001, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b0, 11'h002, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 11'h004, 32'h11223344, 0);
    do_req(1'b1, 2'd0, 1'b0, 11'h005, 32'h000000AB, 0);
    do_req(1'b0, 2'd2, 1'b0, 11'h004, 32'h0, 0);
    check("plan_merge", {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}, 32'h1122AB44);
    do_req(1'b1, 2'd1, 1'b0, 11'h006, 32'h00008001, 1);
    do_req(1'b0, 2'd1, 1'b1, 11'h006, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 11'h006, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 11'h007, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 11'h7FE, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'd0, 1'b0, 11'h000, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b0, 11'h001, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 11'h7FD, 32'h0, 5);
    do_req(1'b1, 2'd3, 1'b0, 11'h010, 32'hFFFFFFFF, 0);
    do_req(1'b0, 2'd1, 1'b0, 11'h003, 32'h0, 0);

    // Reset during WAIT of a byte store: no write, word untouched.
    do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344, 0);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_addr = 11'h011; bus.req_wdata = 32'h000000AB;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_wait_wren", 32'(bus.ram_wren), 32'd0);
    @(negedge clk);
    check("rst_wait_wren2", 32'(bus.ram_wren), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_idle", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 0);

    // Reset inside the WRITE cycle of a word store: wren drops at once, RAM unchanged.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 11'h020; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("write_wren_on", 32'(bus.ram_wren), 32'd1);
    #1 rst = 1'b1;
    #1 check("write_wren_async", 32'(bus.ram_wren), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 2'd2, 1'b0, 11'h020, 32'h0, 0);

    // Random traffic, biased toward a small window and the wrap point.
    for (int n = 0; n < 250; n++) begin
      logic        wr, sg;
      logic [1:0]  sz;
      logic [10:0] ad;
      int          sel;
      wr  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sel = $urandom_range(0, 3);
      if (sel == 0)      ad = 11'(2044 + $urandom_range(0, 7));
      else if (sel == 1) ad = 11'($urandom);
      else               ad = 11'($urandom_range(0, 63));
      do_req(wr, sz, sg, ad, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bram_lsu.md
# bram_lsu

Load/store initiator that drives the 2 KiB unaligned block RAM from a single-request valid/ready port. Accepts byte, half and word loads and stores at any byte address and performs sign/zero extension on loads. Sub-word stores use read-modify-write, because the RAM writes all four byte lanes on every write. It sits between the core's memory stage and the RAM, one request in flight at a time.

## Interface
- ADDR_W, 11, byte address width; fixed to match the 2 KiB RAM.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address, any alignment
- req_wdata  in  32  store data, little-endian from req_addr
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no RAM access made
- ram_raddr  out  ADDR_W  RAM read byte address
- ram_waddr  out  ADDR_W  RAM write byte address
- ram_wdata  out  32  RAM write data
- ram_wren  out  1  RAM write enable
- ram_rdata  in  32  RAM read data; registered, valid the cycle after ram_raddr is presented

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE:
  - On req_valid && req_ready, latch write/size/signed/addr/wdata.
  - size 3 goes to RESP with err=1.
  - Word store goes to WRITE.
  - All others go to READ.
- READ: ram_raddr = latched addr; always goes to WAIT.
- WAIT: ram_rdata is valid.
  - Load: extend into rsp_rdata, then go to RESP.
  - Sub-word store: merge and register into the write buffer, then go to WRITE.
    - Byte: {rdata[31:8], wdata[7:0]}.
    - Half: {rdata[31:16], wdata[15:0]}.
- WRITE: ram_wren = 1 for exactly one cycle, ram_waddr = latched addr, ram_wdata = merged word (or req_wdata for a word store). Then go to RESP.
- RESP: rsp_valid = 1 with rsp_rdata/rsp_err held stable; go to IDLE on rsp_ready.
- Extension:
  - Byte: bits [7:0]. Half: bits [15:0]. Word: unchanged.
  - req_signed = 1 replicates the top bit of the field; 0 zero-fills.
- Address arithmetic:
  - Accesses crossing 0x7FF wrap modulo 2048. A word at 0x7FE covers bytes 0x7FE, 0x7FF, 0x000, 0x001.
  - The LSU performs no range check.
- ram_wren, ram_wdata and ram_waddr are 0 outside WRITE. ram_raddr holds the latched addr in READ/WAIT and is 0 otherwise.
- Only one request is ever outstanding, so RAM read-during-write hazards cannot occur.

## Timing
- Request accepted at edge T. rsp_valid first high in the cycle after:
  - T+3 for loads.
  - T+2 for word stores.
  - T+4 for sub-word stores.
  - T+1 for errors.
- Each RSP cycle with rsp_ready low adds one cycle of latency.
- Throughput: the next request is accepted no earlier than the cycle after the response handshake; req_ready is 0 in all non-IDLE states.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, ram_wren 0, ram_raddr/ram_waddr/ram_wdata 0.
- Reset mid-operation:
  - The request is discarded and no response is issued.
  - ram_wren drops asynchronously with reset.
  - If reset is asserted before the WRITE-cycle clock edge, RAM contents are unchanged.
- rsp_valid must not drop, and rsp_rdata/rsp_err must not change, until rsp_ready is seen.

## Configuration
- BRAM_LSU_ALIGN_CHECK_EN defined:
  - Half requests with addr[0] = 1 and word requests with addr[1:0] != 0 are rejected like size 3.
  - The response is rsp_err = 1 at T+1, with no RAM read or write.
- Undefined: every alignment is legal and only size 3 is rejected.

## Test plan
- Word store 0x12345678 at 0x001, then word load 0x001 -> 0x12345678 with rsp_valid at T+3. Byte load unsigned at 0x002 -> 0x00000056.
- Word 0x11223344 at 0x004, then byte store 0xAB at 0x005 -> exactly one ram_wren pulse, rsp at T+4. Word load at 0x004 -> 0x1122AB44.
- Half 0x8001 at 0x006: signed half load -> 0xFFFF8001; unsigned -> 0x00008001. Signed byte load at 0x007 -> 0xFFFFFF80.
- Wrap: word store 0xDEADBEEF at 0x7FE, then byte loads at 0x000 -> 0xAD and 0x001 -> 0xDE.
- Backpressure and errors:
  - Hold rsp_ready low 5 cycles after a load -> rsp_valid, rsp_rdata and req_ready=0 stable throughout.
  - size 3 -> rsp_err = 1 at T+1, ram_wren never asserted.
- Reset during WAIT of a byte store -> ram_wren never pulses, old word intact, req_ready = 1 after release.
- With BRAM_LSU_ALIGN_CHECK_EN: half load at 0x003 -> rsp_err = 1, no ram_raddr activity.
